// File: rtl/fx2lp_slave_fifo_reader.sv
// FX2LP synchronous slave FIFO reader: drains an OUT endpoint byte by byte and packs
// little-endian words onto an Avalon-ST source.
module fx2lp_slave_fifo_reader #(
  parameter logic [1:0]  EP_ADDR        = 2'b00,
  parameter int unsigned EMPTY_FLAG_IDX = 0,
  parameter int unsigned DATA_BYTES     = 4,
  localparam int unsigned IdxW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1,
  localparam int unsigned DataW = 8 * DATA_BYTES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             flush,
  input  logic [7:0]       fx2lp_fd,
  input  logic [2:0]       fx2lp_flag_n,
  output logic             fx2lp_slrd_n,
  output logic             fx2lp_sloe_n,
  output logic [1:0]       fx2lp_fifoadr,
  output logic [DataW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IdxW-1:0]  byte_idx
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StOe, StCheck, StRead, StWait} state_e;

  state_e           state_q, state_d;
  logic             empty_n_q;
  logic [DataW-1:0] asm_q, asm_d;
  logic [DataW-1:0] data_q, data_d;
  logic [DataW-1:0] word_next;
  logic             valid_q, valid_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             read_ok;
  logic             unused_flags;

  assign unused_flags  = ^fx2lp_flag_n;
  assign fx2lp_fifoadr = EP_ADDR;
  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign byte_idx      = idx_q;

  // Never start a final-byte read while the output word is still held.
  assign read_ok = empty_n_q & enable & ~flush & ~((idx_q == LastIdx) & valid_q & ~out_ready);

  always_comb begin
    state_d      = state_q;
    fx2lp_sloe_n = 1'b1;
    fx2lp_slrd_n = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StOe;
      end
      StOe: begin
        fx2lp_sloe_n = 1'b0;
        state_d      = StCheck;
      end
      StCheck: begin
        fx2lp_sloe_n = 1'b0;
        if (!enable)      state_d = StIdle;
        else if (read_ok) state_d = StRead;
      end
      StRead: begin
        fx2lp_sloe_n = 1'b0;
        fx2lp_slrd_n = 1'b0;
        state_d      = StWait;
      end
      StWait: begin
        fx2lp_sloe_n = 1'b0;
        state_d      = enable ? StCheck : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    asm_d     = asm_q;
    data_d    = data_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    word_next = asm_q;
    word_next[{idx_q, 3'b000} +: 8] = fx2lp_fd;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (flush) begin
      idx_d = '0;
    end else if (state_q == StRead) begin
      asm_d = word_next;
      if (idx_q == LastIdx) begin
        data_d  = word_next;
        valid_d = 1'b1;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      empty_n_q <= 1'b0;
      asm_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      empty_n_q <= fx2lp_flag_n[EMPTY_FLAG_IDX];
      asm_q     <= asm_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
    end
  end

endmodule
